pcr_timebase_ctrl: RTL and testbench

Sequencing controller for the 27 MHz clock divider and owner of the 27 MHz program-clock timebase in the QoS path. It holds the divider in reset and releases it on command, then counts rising edges of the divider output into a 33-bit PCR base and a 9-bit extension (mod 300). Commands to start, stop, load and snapshot the timebase arrive over a valid/ready handshake from the QoS control logic.

---
 rtl/pcr_pkg.sv | 27 ++
 rtl/pcr_timebase_ctrl_if.sv | 30 +++
 rtl/pcr_counter.sv | 60 ++++++
 rtl/pcr_timebase_ctrl.sv | 148 ++++++++++++++
 tb/tb_pcr_timebase_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pcr_pkg.sv
// ---------------------------------------------------------------------------
// pcr_pkg
// Shared definitions for the PCR timebase controller: command opcodes,
// controller state encoding and the default PCR field widths / modulus.
// ---------------------------------------------------------------------------
package pcr_pkg;

    localparam int PCR_BASE_W  = 33;
    localparam int PCR_EXT_W   = 9;
    localparam int PCR_EXT_MOD = 300;

    // Command opcodes carried on cmd_op
    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_STOP  = 2'd1,
        OP_LOAD  = 2'd2,
        OP_SNAP  = 2'd3
    } cmd_op_e;

    // Controller sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/pcr_timebase_ctrl_if.sv
// ---------------------------------------------------------------------------
// pcr_timebase_ctrl_if
// Command channel from the QoS control logic to the timebase controller.
//   cmd_valid / cmd_ready : request / accept handshake
//   cmd_op                : opcode (see pcr_pkg::cmd_op_e)
//   cmd_base / cmd_ext    : LOAD payload
//   cmd_err               : one-cycle pulse, LOAD rejected
// master = command issuer, slave = pcr_timebase_ctrl.
// ---------------------------------------------------------------------------
interface pcr_timebase_ctrl_if #(
    parameter int BASE_W = 33,
    parameter int EXT_W  = 9
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [BASE_W-1:0] cmd_base;
    logic [EXT_W-1:0]  cmd_ext;
    logic              cmd_err;

    modport master (
        output cmd_valid, cmd_op, cmd_base, cmd_ext,
        input  cmd_ready, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_base, cmd_ext,
        output cmd_ready, cmd_err
    );
endinterface

// File: rtl/pcr_counter.sv
// ---------------------------------------------------------------------------
// pcr_counter
// PCR base/extension register pair. The extension counts modulo EXT_MOD and
// carries into the base, which wraps modulo 2^BASE_W. load has priority over
// inc.
// Ports:
//   clk2, rstn          : clock, async active-low reset
//   inc                 : advance by one 27 MHz tick
//   load                : replace value with load_base/load_ext
//   load_base, load_ext : load payload (caller guarantees load_ext < EXT_MOD)
//   base, ext           : current value
// ---------------------------------------------------------------------------
module pcr_counter #(
    parameter int BASE_W  = 33,
    parameter int EXT_W   = 9,
    parameter int EXT_MOD = 300
) (
    input  logic              clk2,
    input  logic              rstn,
    input  logic              inc,
    input  logic              load,
    input  logic [BASE_W-1:0] load_base,
    input  logic [EXT_W-1:0]  load_ext,
    output logic [BASE_W-1:0] base,
    output logic [EXT_W-1:0]  ext
);

    logic [BASE_W-1:0] base_q, base_d;
    logic [EXT_W-1:0]  ext_q,  ext_d;

    always_comb begin
        base_d = base_q;
        ext_d  = ext_q;
        if (load) begin
            base_d = load_base;
            ext_d  = load_ext;
        end else if (inc) begin
            if (ext_q == EXT_W'(EXT_MOD - 1)) begin
                ext_d  = '0;
                base_d = base_q + BASE_W'(1);
            end else begin
                ext_d  = ext_q + EXT_W'(1);
            end
        end
    end

    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            base_q <= '0;
            ext_q  <= '0;
        end else begin
            base_q <= base_d;
            ext_q  <= ext_d;
        end
    end

    assign base = base_q;
    assign ext  = ext_q;

endmodule

// File: rtl/pcr_timebase_ctrl.sv
// ---------------------------------------------------------------------------
// pcr_timebase_ctrl
// Sequences the 27 MHz divider out of reset and counts its rising edges into
// the PCR base/extension timebase.
// Ports:
//   clk2, rstn     : 108 MHz clock, async active-low reset
//   tick_in        : divider output level (synchronous to clk2)
//   div_rstn       : divider reset, active-low
//   cmd            : command channel (START/STOP/LOAD/SNAP)
//   running        : high while counting
//   pcr_base/ext   : live timebase
//   snap_valid     : one-cycle pulse when snap_base/ext are updated
//   snap_base/ext  : timebase captured by the last SNAP
// ---------------------------------------------------------------------------
module pcr_timebase_ctrl
    import pcr_pkg::*;
#(
    parameter int DIV_RST_CYCLES = 4,
    parameter int BASE_W         = PCR_BASE_W,
    parameter int EXT_W          = PCR_EXT_W,
    parameter int EXT_MOD        = PCR_EXT_MOD
) (
    input  logic                 clk2,
    input  logic                 rstn,
    input  logic                 tick_in,
    output logic                 div_rstn,
    pcr_timebase_ctrl_if.slave   cmd,
    output logic                 running,
    output logic [BASE_W-1:0]    pcr_base,
    output logic [EXT_W-1:0]     pcr_ext,
    output logic                 snap_valid,
    output logic [BASE_W-1:0]    snap_base,
    output logic [EXT_W-1:0]     snap_ext
);

    state_e            state_q, state_d;
    logic [7:0]        sync_cnt_q, sync_cnt_d;
    logic              tick_d_q, tick_d_d;
    logic              cmd_err_q, cmd_err_d;
    logic              snap_valid_q, snap_valid_d;
    logic [BASE_W-1:0] snap_base_q, snap_base_d;
    logic [EXT_W-1:0]  snap_ext_q, snap_ext_d;

    logic              cmd_ready;
    logic              accept;
    logic              tick;
    logic              load_ok;
    logic              inc;
    cmd_op_e           op;

    assign op        = cmd_op_e'(cmd.cmd_op);
    assign cmd_ready = (state_q != ST_SYNC);
    assign accept    = cmd.cmd_valid & cmd_ready;
    assign tick      = tick_in & ~tick_d_q & (state_q == ST_RUN);
    assign load_ok   = accept & (op == OP_LOAD) & (cmd.cmd_ext < EXT_W'(EXT_MOD));
    // A valid LOAD overrides a coincident tick; the tick is discarded.
    assign inc       = tick & ~load_ok;

    always_comb begin
        state_d      = state_q;
        sync_cnt_d   = sync_cnt_q;
        tick_d_d     = 1'b1;
        cmd_err_d    = 1'b0;
        snap_valid_d = 1'b0;
        snap_base_d  = snap_base_q;
        snap_ext_d   = snap_ext_q;

        case (state_q)
            ST_IDLE: begin
                if (accept && op == OP_START) begin
                    state_d    = ST_SYNC;
                    sync_cnt_d = '0;
                end
            end
            ST_SYNC: begin
                if (sync_cnt_q == 8'(DIV_RST_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    sync_cnt_d = sync_cnt_q + 8'd1;
                end
            end
            ST_RUN: begin
                // Only track the real level while counting; the forced 1
                // elsewhere hides the divider's post-reset high level.
                tick_d_d = tick_in;
                if (accept && op == OP_STOP) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept && op == OP_LOAD && !load_ok) begin
            cmd_err_d = 1'b1;
        end

        // Snapshot takes the pre-update value of the acceptance cycle.
        if (accept && op == OP_SNAP) begin
            snap_valid_d = 1'b1;
            snap_base_d  = pcr_base;
            snap_ext_d   = pcr_ext;
        end
    end

    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            sync_cnt_q   <= '0;
            tick_d_q     <= 1'b1;
            cmd_err_q    <= 1'b0;
            snap_valid_q <= 1'b0;
            snap_base_q  <= '0;
            snap_ext_q   <= '0;
        end else begin
            state_q      <= state_d;
            sync_cnt_q   <= sync_cnt_d;
            tick_d_q     <= tick_d_d;
            cmd_err_q    <= cmd_err_d;
            snap_valid_q <= snap_valid_d;
            snap_base_q  <= snap_base_d;
            snap_ext_q   <= snap_ext_d;
        end
    end

    pcr_counter #(
        .BASE_W  (BASE_W),
        .EXT_W   (EXT_W),
        .EXT_MOD (EXT_MOD)
    ) u_counter (
        .clk2      (clk2),
        .rstn      (rstn),
        .inc       (inc),
        .load      (load_ok),
        .load_base (cmd.cmd_base),
        .load_ext  (cmd.cmd_ext),
        .base      (pcr_base),
        .ext       (pcr_ext)
    );

    assign cmd.cmd_ready = cmd_ready;
    assign cmd.cmd_err   = cmd_err_q;
    assign div_rstn      = (state_q == ST_RUN);
    assign running       = (state_q == ST_RUN);
    assign snap_valid    = snap_valid_q;
    assign snap_base     = snap_base_q;
    assign snap_ext      = snap_ext_q;

endmodule

// File: tb/tb_pcr_timebase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pcr_timebase_ctrl
// Self-checking bench for pcr_timebase_ctrl. The reference model keeps the
// timebase as a single count of 27 MHz ticks (base*300 + ext) and derives
// base/ext from it arithmetically.
// ---------------------------------------------------------------------------
module tb_pcr_timebase_ctrl;

    localparam int N_SYNC = 4;
    localparam longint unsigned MODT = 64'd300 << 33;

    logic        clk2 = 1'b0;
    logic        rstn;
    logic        tick_in;
    logic        div_rstn;
    logic        running;
    logic [32:0] pcr_base;
    logic [8:0]  pcr_ext;
    logic        snap_valid;
    logic [32:0] snap_base;
    logic [8:0]  snap_ext;

    pcr_timebase_ctrl_if #(.BASE_W(33), .EXT_W(9)) cmd_if ();

    pcr_timebase_ctrl #(
        .DIV_RST_CYCLES (N_SYNC),
        .BASE_W         (33),
        .EXT_W          (9),
        .EXT_MOD        (300)
    ) dut (
        .clk2       (clk2),
        .rstn       (rstn),
        .tick_in    (tick_in),
        .div_rstn   (div_rstn),
        .cmd        (cmd_if),
        .running    (running),
        .pcr_base   (pcr_base),
        .pcr_ext    (pcr_ext),
        .snap_valid (snap_valid),
        .snap_base  (snap_base),
        .snap_ext   (snap_ext)
    );

    always #5 clk2 = ~clk2;

    int checks   = 0;
    int failures = 0;

    // Reference model: 0 = idle, 1 = sync, 2 = run
    int              m_mode;
    int              m_sync_left;
    bit              m_prev;
    longint unsigned m_total;
    longint unsigned m_snap;
    bit              m_err;
    bit              m_sv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_sync_left = 0; m_prev = 1'b1;
        m_total = 0; m_snap = 0; m_err = 1'b0; m_sv = 1'b0;
    endtask

    task automatic check_all();
        chk("cmd_ready",  {63'd0, cmd_if.cmd_ready}, {63'd0, m_mode != 1});
        chk("div_rstn",   {63'd0, div_rstn},         {63'd0, m_mode == 2});
        chk("running",    {63'd0, running},          {63'd0, m_mode == 2});
        chk("pcr_base",   {31'd0, pcr_base},         m_total / 300);
        chk("pcr_ext",    {55'd0, pcr_ext},          m_total % 300);
        chk("cmd_err",    {63'd0, cmd_if.cmd_err},   {63'd0, m_err});
        chk("snap_valid", {63'd0, snap_valid},       {63'd0, m_sv});
        chk("snap_base",  {31'd0, snap_base},        m_snap / 300);
        chk("snap_ext",   {55'd0, snap_ext},         m_snap % 300);
    endtask

    // One clock cycle: drive at negedge, advance model at posedge, check after.
    task automatic step(input bit v, input logic [1:0] op, input logic [32:0] b,
                        input logic [8:0] e, input bit t);
        bit acc, edge_seen;
        @(negedge clk2);
        cmd_if.cmd_valid = v;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_base  = b;
        cmd_if.cmd_ext   = e;
        tick_in          = t;
        @(posedge clk2);
        acc       = v && (m_mode != 1);
        edge_seen = t && !m_prev && (m_mode == 2);
        m_err     = acc && op == 2'd2 && e >= 9'd300;
        m_sv      = acc && op == 2'd3;
        if (m_sv) m_snap = m_total;
        if (acc && op == 2'd2 && e < 9'd300)
            m_total = longint'(b) * 300 + longint'(e);
        else if (edge_seen)
            m_total = (m_total + 1) % MODT;
        m_prev = (m_mode == 2) ? t : 1'b1;
        case (m_mode)
            0: if (acc && op == 2'd0) begin m_mode = 1; m_sync_left = N_SYNC; end
            1: begin m_sync_left--; if (m_sync_left == 0) m_mode = 2; end
            default: if (acc && op == 2'd1) m_mode = 0;
        endcase
        #1;
        check_all();
    endtask

    task automatic idle(input bit t);
        step(1'b0, 2'd0, '0, '0, t);
    endtask

    task automatic do_reset();
        @(negedge clk2);
        cmd_if.cmd_valid = 1'b0;
        #2 rstn = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk2);
        rstn = 1'b1;
    endtask

    initial begin
        int n, low_cnt;
        bit t;
        logic [63:0] rb;
        logic [1:0]  rop;

        rstn = 1'b0;
        tick_in = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op = 2'd0;
        cmd_if.cmd_base = '0;
        cmd_if.cmd_ext = '0;
        model_reset();
        #3;
        check_all();
        do_reset();

        // START with the divider output already high; it must not be counted.
        step(1'b1, 2'd0, '0, '0, 1'b1);
        n = 1;
        low_cnt = cmd_if.cmd_ready ? 0 : 1;
        while (!div_rstn && n < 20) begin
            idle(1'b1);
            n++;
            if (!cmd_if.cmd_ready) low_cnt++;
        end
        chk("start_latency", 64'(n), 64'(N_SYNC + 1));
        chk("ready_low_cycles", 64'(low_cnt), 64'(N_SYNC));
        idle(1'b1);
        idle(1'b1);
        chk("no_initial_tick", {55'd0, pcr_ext}, 64'd0);

        // 300 rising edges, tick_in toggling every 2 cycles.
        for (int i = 0; i < 1200; i++) idle(((i / 2) % 2) == 1);
        chk("base_after_300", {31'd0, pcr_base}, 64'd1);
        chk("ext_after_300",  {55'd0, pcr_ext},  64'd0);

        // Wrap of the full 33-bit base.
        step(1'b1, 2'd2, 33'h1_FFFF_FFFF, 9'd299, 1'b0);
        idle(1'b1);
        chk("wrap_base", {31'd0, pcr_base}, 64'd0);
        chk("wrap_ext",  {55'd0, pcr_ext},  64'd0);

        // Rejected LOAD.
        step(1'b1, 2'd2, 33'd123, 9'd300, 1'b0);
        chk("rej_err",  {63'd0, cmd_if.cmd_err}, 64'd1);
        chk("rej_base", {31'd0, pcr_base}, 64'd0);
        chk("rej_ext",  {55'd0, pcr_ext},  64'd0);
        idle(1'b0);
        chk("rej_err_pulse", {63'd0, cmd_if.cmd_err}, 64'd0);

        // LOAD coincident with a tick: tick is lost.
        step(1'b1, 2'd2, 33'd77, 9'd5, 1'b1);
        idle(1'b1);
        chk("load_tick_base", {31'd0, pcr_base}, 64'd77);
        chk("load_tick_ext",  {55'd0, pcr_ext},  64'd5);

        // SNAP coincident with a tick.
        step(1'b1, 2'd2, 33'd5, 9'd10, 1'b0);
        idle(1'b0);
        step(1'b1, 2'd3, '0, '0, 1'b1);
        chk("snap_valid_hi", {63'd0, snap_valid}, 64'd1);
        chk("snap_base_val", {31'd0, snap_base}, 64'd5);
        chk("snap_ext_val",  {55'd0, snap_ext},  64'd10);
        chk("live_ext_val",  {55'd0, pcr_ext},   64'd11);
        idle(1'b1);
        chk("snap_valid_lo", {63'd0, snap_valid}, 64'd0);

        // STOP, then the counters hold through further edges.
        step(1'b1, 2'd1, '0, '0, 1'b0);
        chk("stop_div_rstn", {63'd0, div_rstn}, 64'd0);
        for (int i = 0; i < 20; i++) idle(i[0]);
        chk("stop_hold_ext", {55'd0, pcr_ext}, 64'd11);

        // Reset mid-SYNC and mid-RUN.
        step(1'b1, 2'd0, '0, '0, 1'b1);
        idle(1'b1);
        do_reset();
        step(1'b1, 2'd0, '0, '0, 1'b1);
        for (int i = 0; i < 10; i++) idle(i[0]);
        do_reset();

        // Randomized traffic.
        t = 1'b0;
        step(1'b1, 2'd0, '0, '0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            rb  = {$urandom(), $urandom()};
            rop = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) t = ~t;
            if ($urandom_range(0, 3) == 0)
                step(1'b1, rop, rb[32:0], 9'($urandom_range(0, 310)), t);
            else
                idle(t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
